// File: rtl/change_dispenser.sv
// Soda chute driver and coin payout engine for one vending transaction.
// Pays change greedily (dimes first) over req/ack and tracks hopper inventory.
module change_dispenser #(
    parameter int             CNT_W       = 8,
    parameter logic [CNT_W-1:0] NICKEL_INIT = 8'd20,
    parameter logic [CNT_W-1:0] DIME_INIT   = 8'd20,
    parameter int             ACK_TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_soda,
    input  logic [2:0]       i_change,
    input  logic             i_vend_ack,
    input  logic             i_coin_ack,
    input  logic             i_refill,
    output logic             o_vend_req,
    output logic             o_dime_req,
    output logic             o_nickel_req,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_short,
    output logic             o_timeout,
    output logic             o_overrun,
    output logic [CNT_W-1:0] o_nickel_cnt,
    output logic [CNT_W-1:0] o_dime_cnt
);

    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, VEND, SEL, COIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        rem_q, rem_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  nickel_q, nickel_d;
    logic [CNT_W-1:0]  dime_q, dime_d;
    logic              vend_req_q, vend_req_d;
    logic              dime_req_q, dime_req_d;
    logic              nickel_req_q, nickel_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              short_q, short_d;
    logic              timeout_q, timeout_d;
    logic              overrun_q, overrun_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            wait_q       <= '0;
            nickel_q     <= NICKEL_INIT;
            dime_q       <= DIME_INIT;
            vend_req_q   <= 1'b0;
            dime_req_q   <= 1'b0;
            nickel_req_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            wait_q       <= wait_d;
            nickel_q     <= nickel_d;
            dime_q       <= dime_d;
            vend_req_q   <= vend_req_d;
            dime_req_q   <= dime_req_d;
            nickel_req_q <= nickel_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            short_q      <= short_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        wait_d       = wait_q;
        nickel_d     = nickel_q;
        dime_d       = dime_q;
        dime_req_d   = 1'b0;
        nickel_req_d = 1'b0;
        short_d      = short_q;
        timeout_d    = timeout_q;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (i_soda) begin
                    state_d = VEND;
                    wait_d  = '0;
                    if (i_change > 3'd4) begin
                        rem_d   = 3'd4;
                        short_d = 1'b1;
                    end else begin
                        rem_d = i_change;
                    end
                end else if (i_refill) begin
                    nickel_d = NICKEL_INIT;
                    dime_d   = DIME_INIT;
                    short_d  = 1'b0;
                end
            end
            VEND: begin
                if (i_vend_ack) begin
                    state_d = SEL;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            // Selection guards on nonzero inventory, so the counters never wrap.
            SEL: begin
                wait_d = '0;
                if (rem_q == 3'd0) begin
                    state_d = DONE;
                end else if (rem_q >= 3'd2 && dime_q != '0) begin
                    state_d    = COIN;
                    dime_req_d = 1'b1;
                end else if (nickel_q != '0) begin
                    state_d      = COIN;
                    nickel_req_d = 1'b1;
                end else begin
                    short_d = 1'b1;
                    state_d = DONE;
                end
            end
            COIN: begin
                if (i_coin_ack) begin
                    state_d = SEL;
                    if (dime_req_q) begin
                        rem_d  = rem_q - 3'd2;
                        dime_d = dime_q - CNT_W'(1);
                    end else begin
                        rem_d    = rem_q - 3'd1;
                        nickel_d = nickel_q - CNT_W'(1);
                    end
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    wait_d       = wait_q + 1'b1;
                    dime_req_d   = dime_req_q;
                    nickel_req_d = nickel_req_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE && i_soda) begin
            overrun_d = 1'b1;
        end

        vend_req_d = (state_d == VEND);
        done_d     = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    assign o_vend_req   = vend_req_q;
    assign o_dime_req   = dime_req_q;
    assign o_nickel_req = nickel_req_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_short      = short_q;
    assign o_timeout    = timeout_q;
    assign o_overrun    = overrun_q;
    assign o_nickel_cnt = nickel_q;
    assign o_dime_cnt   = dime_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed corner cases plus random
// transactions checked against an arithmetic model of the payout rules.
module tb_change_dispenser;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       soda, vendAck, coinAck, refill;
    logic [2:0] change;
    logic       vendReq, dimeReq, nickelReq, busy, done, shortF, timeoutF, overrunF;
    logic [7:0] nickelCnt, dimeCnt;

    int total = 0;
    int bad   = 0;
    int mN, mD;
    bit mShort, mTimeout, mOverrun;

    always #5 clk = ~clk;

    change_dispenser #(
        .CNT_W(8), .NICKEL_INIT(8'd20), .DIME_INIT(8'd20), .ACK_TIMEOUT(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_soda(soda), .i_change(change),
        .i_vend_ack(vendAck), .i_coin_ack(coinAck), .i_refill(refill),
        .o_vend_req(vendReq), .o_dime_req(dimeReq), .o_nickel_req(nickelReq),
        .o_busy(busy), .o_done(done), .o_short(shortF), .o_timeout(timeoutF),
        .o_overrun(overrunF), .o_nickel_cnt(nickelCnt), .o_dime_cnt(dimeCnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mN = 20; mD = 20; mShort = 0; mTimeout = 0; mOverrun = 0;
    endtask

    // Payout rule in closed form: as many dimes as fit, then nickels, rest forfeited.
    task automatic modelTxn(input int c, output int dUsed, output int nUsed);
        int rem;
        rem = (c > 4) ? 4 : c;
        if (c > 4) mShort = 1;
        dUsed = (rem / 2 < mD) ? rem / 2 : mD;
        rem   = rem - 2 * dUsed;
        nUsed = (rem < mN) ? rem : mN;
        if (rem > nUsed) mShort = 1;
        mD = mD - dUsed;
        mN = mN - nUsed;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".nickels"}, nickelCnt, mN);
        checkOutput({tag, ".dimes"},   dimeCnt,   mD);
        checkOutput({tag, ".short"},   shortF,    mShort);
        checkOutput({tag, ".timeout"}, timeoutF,  mTimeout);
        checkOutput({tag, ".overrun"}, overrunF,  mOverrun);
        checkOutput({tag, ".busy"},    busy,      0);
    endtask

    task automatic doRefill();
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        mN = 20; mD = 20; mShort = 0;
        checkIdle("refill");
    endtask

    task automatic applyStimulus(input int c, input bit randAck, input int sodaAt, input bit withRefill);
        int  dExp, nExp, k, dSeen, nSeen;
        bit  pd, pn, orderOk, oneHot;
        k = 0; dSeen = 0; nSeen = 0; pd = 0; pn = 0; orderOk = 1; oneHot = 1;
        modelTxn(c, dExp, nExp);
        if (sodaAt >= 0) mOverrun = 1;
        vendAck = 1'b1; coinAck = 1'b1;
        soda = 1'b1; change = c[2:0]; refill = withRefill;
        @(negedge clk);
        soda = 1'b0; refill = 1'b0; change = 3'd7;
        checkOutput("txn.vend_req_on_capture", vendReq, 1);
        checkOutput("txn.busy_on_capture", busy, 1);
        while (!done && k < 300) begin
            if (randAck) begin
                vendAck = ($urandom_range(0, 3) != 0);
                coinAck = ($urandom_range(0, 3) != 0);
            end
            soda = (k == sodaAt);
            @(negedge clk);
            k++;
            soda = 1'b0;
            if (dimeReq && !pd) begin
                dSeen++;
                if (nSeen > 0) orderOk = 0;
            end
            if (nickelReq && !pn) nSeen++;
            if ((dimeReq + nickelReq + vendReq) > 1) oneHot = 0;
            pd = dimeReq; pn = nickelReq;
        end
        checkOutput("txn.done_seen", done, 1);
        if (!randAck) checkOutput("txn.cycles", k, 2 + 2 * (dExp + nExp));
        checkOutput("txn.dimes_paid", dSeen, dExp);
        checkOutput("txn.nickels_paid", nSeen, nExp);
        checkOutput("txn.dimes_first", orderOk, 1);
        checkOutput("txn.one_req", oneHot, 1);
        vendAck = 1'b0; coinAck = 1'b0; change = 3'd0;
        @(negedge clk);
        checkOutput("txn.done_one_cycle", done, 0);
        checkIdle("txn");
    endtask

    initial begin
        int t;
        rst = 1'b1; soda = 0; change = 0; vendAck = 0; coinAck = 0; refill = 0;
        modelReset();
        #1;
        checkOutput("reset.vend_req", vendReq, 0);
        checkOutput("reset.dime_req", dimeReq, 0);
        checkOutput("reset.nickel_req", nickelReq, 0);
        checkOutput("reset.done", done, 0);
        checkIdle("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic change=3 with acks tied high");
        applyStimulus(3, 0, -1, 0);
        checkOutput("basic.dimes19", dimeCnt, 19);
        checkOutput("basic.nickels19", nickelCnt, 19);

        $display("[TB] drain dimes, then nickel-only payout");
        doRefill();
        for (int i = 0; i < 10; i++) applyStimulus(4, 0, -1, 0);
        checkOutput("drain.dimes0", dimeCnt, 0);
        applyStimulus(4, 0, -1, 1);
        checkOutput("nickonly.nickels16", nickelCnt, 16);
        checkOutput("nickonly.short0", shortF, 0);

        $display("[TB] empty hoppers give short change");
        for (int i = 0; i < 4; i++) applyStimulus(4, 0, -1, 0);
        applyStimulus(1, 0, -1, 0);
        checkOutput("empty.short1", shortF, 1);
        doRefill();
        applyStimulus(5, 0, -1, 0);
        doRefill();

        $display("[TB] overrun during busy");
        applyStimulus(2, 0, 2, 0);

        $display("[TB] coin ack timeout");
        vendAck = 1'b1; coinAck = 1'b0;
        soda = 1'b1; change = 3'd2;
        @(negedge clk);
        soda = 1'b0; change = 3'd0;
        t = 0;
        while (!dimeReq && t < 20) begin @(negedge clk); t++; end
        checkOutput("timeout.dime_req", dimeReq, 1);
        t = 0;
        while (!done && t < 50) begin @(negedge clk); t++; end
        checkOutput("timeout.cycles", t, TO);
        checkOutput("timeout.req_dropped", dimeReq, 0);
        mTimeout = 1;
        vendAck = 1'b0;
        @(negedge clk);
        checkIdle("timeout");

        $display("[TB] random transactions");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) doRefill();
            applyStimulus($urandom_range(0, 7), $urandom_range(0, 1), -1, 0);
        end

        $display("[TB] async reset mid-coin");
        vendAck = 1'b1; coinAck = 1'b0;
        soda = 1'b1; change = 3'd3;
        @(negedge clk);
        soda = 1'b0; change = 3'd0;
        t = 0;
        while (!dimeReq && t < 20) begin @(negedge clk); t++; end
        checkOutput("arst.dime_req_before", dimeReq, 1);
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkOutput("arst.dime_req", dimeReq, 0);
        checkOutput("arst.vend_req", vendReq, 0);
        checkIdle("arst");
        vendAck = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkIdle("arst.after");
        applyStimulus(3, 0, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
